// File: rtl/run_sequencer_if.sv
// Purpose : bundles the run handshake, fetch-unit PC signals and run statistics of run_sequencer.
// Latency : pure wiring, no storage.
// Backpressure: none here; stall travels as a plain level from datapath to sequencer.
// Ports   : slave = the sequencer itself; master = bench / fetch-unit side.
interface run_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  // handshake with the bench
  logic          req;
  logic [1:0]    prog_sel;
  logic          busy;
  logic          done;
  logic          timeout;
  // fetch unit / datapath
  logic [D-1:0]  prog_ctr;
  logic          halt;
  logic          stall;
  logic          pc_init;
  logic          pc_en;
  logic [D-1:0]  start_addr;
  // run statistics
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instr_cnt;

  modport slave (
    input  req, prog_sel, prog_ctr, halt, stall,
    output busy, done, timeout, pc_init, pc_en, start_addr, cycle_cnt, instr_cnt
  );

  modport master (
    output req, prog_sel, prog_ctr, halt, stall,
    input  busy, done, timeout, pc_init, pc_en, start_addr, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/run_sequencer.sv
// Purpose : program-run controller; loads the PC with the selected program's start, gates PC
//           advance around stalls, ends on halt / END_PC / watchdog, counts cycles and retires.
// Latency : req seen in IDLE -> INIT next cycle -> first RUN cycle after that; done rises one
//           cycle after the terminating RUN cycle.
// Backpressure: stall freezes PC advance and instr_cnt while cycle_cnt (watchdog) keeps running.
// Ports   : clk, Start (sync active-high reset, shared with the PC), bus (run_sequencer_if.slave).
module run_sequencer #(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int END_PC  = 128,
  parameter int STRIDE  = 256,
  parameter int TIMEOUT = 4000
) (
  input logic            clk,
  input logic            Start,
  run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic          timeout_q;
  logic [D-1:0]  start_addr_q;
  logic [CW-1:0] cycle_q;
  logic [CW-1:0] instr_q;

  // Program base address; upper bits beyond D are dropped.
  localparam bit STRIDE_POW2 = (STRIDE > 0) && ((STRIDE & (STRIDE - 1)) == 0);
  localparam int STRIDE_SH   = (STRIDE > 1) ? $clog2(STRIDE) : 0;

  logic [D-1:0] start_addr_nxt;

  generate
    if (STRIDE_POW2) begin : g_shift
      assign start_addr_nxt = D'(bus.prog_sel) << STRIDE_SH;
    end else begin : g_mul
      assign start_addr_nxt = D'(bus.prog_sel) * D'(STRIDE);
    end
  endgenerate

  // The END_PC slot is never executed, so it can neither retire nor advance the PC.
  logic atend;
  logic retire;
  logic in_run;

  assign atend  = (bus.prog_ctr == D'(END_PC));
  assign retire = ~bus.stall & ~atend;
  assign in_run = (state == RUN);

  // A retiring halt counts as an instruction but leaves the PC parked on it.
  assign bus.pc_en   = in_run & retire & ~bus.halt;
  assign bus.pc_init = (state == INIT);

  always_ff @(posedge clk) begin
    if (Start) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_addr_q <= '0;
      cycle_q      <= '0;
      instr_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            start_addr_q <= start_addr_nxt;
            // Cleared on entry so INIT already reads zero.
            cycle_q      <= '0;
            instr_q      <= '0;
            busy_q       <= 1'b1;
            state        <= INIT;
          end
        end
        INIT: begin
          state <= RUN;
        end
        RUN: begin
          cycle_q <= cycle_q + CW'(1);
          if (retire) begin
            instr_q <= instr_q + CW'(1);
          end
          // Completion outranks the watchdog when both land on the same cycle.
          if (atend || (bus.halt && retire)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (cycle_q == CW'(TIMEOUT - 1)) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state     <= FAULT;
          end
        end
        DONE, FAULT: begin
          // Four-phase release: wait for req to drop, never auto-restart.
          if (!bus.req) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.start_addr = start_addr_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.instr_cnt  = instr_q;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;
  localparam int D  = 12;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus, fanned out to three instances with different watchdogs
  logic         rst;
  logic         req;
  logic [1:0]   prog_sel;
  logic         stall;
  logic         halt_en;
  logic [D-1:0] halt_pc;

  run_sequencer_if #(.D(D), .CW(CW)) if0 ();
  run_sequencer_if #(.D(D), .CW(CW)) if1 ();
  run_sequencer_if #(.D(D), .CW(CW)) if2 ();

  run_sequencer #(.D(D), .CW(CW), .END_PC(128), .STRIDE(256), .TIMEOUT(4000))
    dut0 (.clk(clk), .Start(rst), .bus(if0.slave));
  run_sequencer #(.D(D), .CW(CW), .END_PC(128), .STRIDE(256), .TIMEOUT(20))
    dut1 (.clk(clk), .Start(rst), .bus(if1.slave));
  run_sequencer #(.D(D), .CW(CW), .END_PC(128), .STRIDE(256), .TIMEOUT(10))
    dut2 (.clk(clk), .Start(rst), .bus(if2.slave));

  // fetch-unit models: one PC per instance, reset by the same Start net
  logic [D-1:0] pc0, pc1, pc2;
  always @(posedge clk) begin
    if (rst) pc0 <= '0; else if (if0.pc_init) pc0 <= if0.start_addr; else if (if0.pc_en) pc0 <= pc0 + 1'b1;
    if (rst) pc1 <= '0; else if (if1.pc_init) pc1 <= if1.start_addr; else if (if1.pc_en) pc1 <= pc1 + 1'b1;
    if (rst) pc2 <= '0; else if (if2.pc_init) pc2 <= if2.start_addr; else if (if2.pc_en) pc2 <= pc2 + 1'b1;
  end

  assign if0.req = req;  assign if0.prog_sel = prog_sel;  assign if0.stall = stall;
  assign if1.req = req;  assign if1.prog_sel = prog_sel;  assign if1.stall = stall;
  assign if2.req = req;  assign if2.prog_sel = prog_sel;  assign if2.stall = stall;
  assign if0.prog_ctr = pc0;  assign if0.halt = halt_en && (pc0 == halt_pc);
  assign if1.prog_ctr = pc1;  assign if1.halt = halt_en && (pc1 == halt_pc);
  assign if2.prog_ctr = pc2;  assign if2.halt = halt_en && (pc2 == halt_pc);

  // view of the instance under test
  int            sel = 0;
  logic          s_busy, s_done, s_to, s_pc_init, s_pc_en;
  logic [D-1:0]  s_sa, s_pc;
  logic [CW-1:0] s_cyc, s_ins;

  always_comb begin
    s_busy = if0.busy; s_done = if0.done; s_to = if0.timeout; s_pc_init = if0.pc_init;
    s_pc_en = if0.pc_en; s_sa = if0.start_addr; s_pc = pc0; s_cyc = if0.cycle_cnt; s_ins = if0.instr_cnt;
    case (sel)
      1: begin
        s_busy = if1.busy; s_done = if1.done; s_to = if1.timeout; s_pc_init = if1.pc_init;
        s_pc_en = if1.pc_en; s_sa = if1.start_addr; s_pc = pc1; s_cyc = if1.cycle_cnt; s_ins = if1.instr_cnt;
      end
      2: begin
        s_busy = if2.busy; s_done = if2.done; s_to = if2.timeout; s_pc_init = if2.pc_init;
        s_pc_en = if2.pc_en; s_sa = if2.start_addr; s_pc = pc2; s_cyc = if2.cycle_cnt; s_ins = if2.instr_cnt;
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // per-RUN-cycle stall pattern, shared by the model and the driver
  bit stall_seq [5000];

  // Whole-run reference: walk the program instruction by instruction.
  function automatic void model_run(input int start, input int tmo, input bit hen, input int hpc,
                                    output int cyc, output int ins, output bit to, output int fpc);
    int pc;
    pc = start; cyc = 0; ins = 0; to = 0;
    while (cyc < 5000) begin
      if (pc == 128) begin cyc++; break; end
      if (!stall_seq[cyc]) begin
        ins++;
        if (hen && pc == hpc) begin cyc++; break; end
        pc = (pc + 1) % 4096;
      end
      cyc++;
      if (cyc == tmo) begin to = 1; break; end
    end
    fpc = pc;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req = 0; stall = 0; halt_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // mode: 0 = random stalls at pct %, 1 = stall held, 2 = exactly three stalls
  task automatic run_case(input string tag, input int dut, input logic [1:0] ps, input bit hen,
                          input int hpc, input int mode, input int pct, input int hold,
                          input bit drop_early);
    int tmo, start, e_cyc, e_ins, e_fpc, n_run, n_en;
    bit e_to, ended, held_ok;
    do_reset();
    sel = dut;
    tmo = (dut == 0) ? 4000 : (dut == 1) ? 20 : 10;
    for (int i = 0; i < 5000; i++)
      stall_seq[i] = (mode == 1) ? 1'b1 :
                     (mode == 2) ? (i == 10 || i == 50 || i == 90) :
                     ($urandom_range(0, 99) < pct);
    start = (int'(ps) * 256) % 4096;
    model_run(start, tmo, hen, hpc, e_cyc, e_ins, e_to, e_fpc);

    req = 1; prog_sel = ps; halt_en = hen; halt_pc = D'(hpc);
    @(negedge clk); #1;
    check({tag, ".init_pc_init"}, s_pc_init, 1);
    check({tag, ".init_start_addr"}, s_sa, start);
    check({tag, ".init_cycle_cnt"}, s_cyc, 0);
    if (drop_early) req = 0;

    n_run = 0; n_en = 0; ended = 0;
    for (int guard = 0; guard < 4990 && !ended; guard++) begin
      @(negedge clk);
      stall = stall_seq[n_run];
      prog_sel = 2'($urandom_range(0, 3));
      #1;
      if (s_done) ended = 1;
      else begin
        if (n_run == 0) check({tag, ".first_pc"}, s_pc, start);
        if (s_pc_en) n_en++;
        n_run++;
      end
    end
    check({tag, ".ended"}, ended, 1);
    check({tag, ".run_cycles"}, n_run, e_cyc);
    check({tag, ".timeout"}, s_to, e_to);
    check({tag, ".busy_at_done"}, s_busy, 0);
    check({tag, ".cycle_cnt"}, s_cyc, e_cyc);
    check({tag, ".instr_cnt"}, s_ins, e_ins);
    check({tag, ".pc_en_cycles"}, n_en, (e_fpc - start + 4096) % 4096);
    check({tag, ".final_pc"}, s_pc, e_fpc);
    check({tag, ".start_addr_held"}, s_sa, start);

    held_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (!s_done || s_cyc != CW'(e_cyc)) held_ok = 0;
    end
    if (hold > 0) check({tag, ".held_in_done"}, held_ok, 1);
    req = 0;
    @(negedge clk); #1;
    check({tag, ".release_done"}, s_done, 0);
    check({tag, ".release_timeout"}, s_to, 0);
    check({tag, ".release_cnt_hold"}, s_cyc, e_cyc);
  endtask

  task automatic reset_test();
    int exp_sa;
    exp_sa = (2 * 256) % 4096;
    sel = 0;
    @(negedge clk);
    rst = 1; req = 1; prog_sel = 2; stall = 0; halt_en = 0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rst.busy", s_busy, 0);
    check("rst.done", s_done, 0);
    check("rst.timeout", s_to, 0);
    check("rst.pc_init", s_pc_init, 0);
    check("rst.pc_en", s_pc_en, 0);
    check("rst.start_addr", s_sa, 0);
    check("rst.cycle_cnt", s_cyc, 0);
    check("rst.instr_cnt", s_ins, 0);
    rst = 0;
    @(negedge clk); #1;
    check("rst.release_pc_init", s_pc_init, 1);
    check("rst.release_start_addr", s_sa, exp_sa);
  endtask

  task automatic midrun_reset_test();
    do_reset();
    sel = 0; req = 1; prog_sel = 1; stall = 0;
    @(negedge clk);                     // INIT
    @(negedge clk);                     // RUN cycle 1
    @(negedge clk);                     // RUN cycle 2
    @(negedge clk); #1;                 // RUN cycle 3
    check("mid.busy_before", s_busy, 1);
    rst = 1;
    @(negedge clk); #1;
    check("mid.busy", s_busy, 0);
    check("mid.done", s_done, 0);
    check("mid.cycle_cnt", s_cyc, 0);
    check("mid.instr_cnt", s_ins, 0);
    check("mid.start_addr", s_sa, 0);
    rst = 0; req = 0;
  endtask

  initial begin
    rst = 1; req = 0; prog_sel = 0; stall = 0; halt_en = 0; halt_pc = '0;
    run_case("halt", 0, 2'd0, 1'b1, 5, 0, 0, 0, 1'b0);
    reset_test();
    run_case("eop", 0, 2'd0, 1'b0, 0, 2, 0, 0, 1'b0);
    run_case("wdog", 1, 2'd0, 1'b0, 0, 1, 0, 0, 1'b0);
    run_case("race", 2, 2'd0, 1'b1, 9, 0, 0, 0, 1'b0);
    run_case("hold", 0, 2'd1, 1'b1, 256 + 20, 0, 20, 5, 1'b0);
    midrun_reset_test();
    for (int r = 0; r < 12; r++) begin
      int dut, hpc, pct, hold;
      logic [1:0] ps;
      bit hen, drop;
      dut  = $urandom_range(0, 2);
      ps   = 2'($urandom_range(0, 3));
      pct  = $urandom_range(0, 50);
      drop = 1'($urandom_range(0, 1));
      hold = drop ? 0 : $urandom_range(0, 4);
      if (ps == 2'd0) begin
        hen = 1'($urandom_range(0, 1));
        hpc = $urandom_range(0, 140);
      end else begin
        hen = ($urandom_range(0, 3) != 0);
        hpc = int'(ps) * 256 + $urandom_range(0, 60);
      end
      run_case($sformatf("rnd%0d", r), dut, ps, hen, hpc, 0, pct, hold, drop);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Program-run controller between the bench handshake (`req`/`done`) and the fetch unit (PC, PC_LUT, instr_ROM).
- On request, it loads the PC with the selected program's start address, then gates PC advance around datapath stalls.
- It ends the run on a halt instruction, on end-of-program PC, or on a watchdog timeout.
- It reports cycle and retired-instruction counts.

## Interface

Parameters:
- `D`, 12: program counter width.
- `CW`, 16: counter width for `cycle_cnt` and `instr_cnt`.
- `END_PC`, 128: PC value that ends a run; never executed.
- `STRIDE`, 256: address spacing between programs. `start_addr = prog_sel * STRIDE`, truncated to D bits.
- `TIMEOUT`, 4000: maximum RUN cycles. Must satisfy 1 ≤ TIMEOUT < 2^CW.

Ports:
- `clk`  in  1: single clock; everything samples on the rising edge.
- `Start`  in  1: reset, synchronous, active-high. It is the same net that resets the PC.
- `req`  in  1: run request, level-sensitive, four-phase handshake.
- `prog_sel`  in  2: program select, sampled in IDLE when `req`=1.
- `prog_ctr`  in  D: current PC.
- `halt`  in  1: Control has decoded a halt instruction at `prog_ctr`.
- `stall`  in  1: datapath is not ready to retire this cycle.
- `pc_init`  out  1: PC loads `start_addr` on the next edge.
- `pc_en`  out  1: PC advances on the next edge.
- `start_addr`  out  D: registered start address.
- `busy`  out  1: a run is in progress (INIT or RUN).
- `done`  out  1: run finished (DONE or FAULT).
- `timeout`  out  1: run ended by the watchdog (FAULT).
- `cycle_cnt`  out  CW: number of RUN cycles in the current or last run.
- `instr_cnt`  out  CW: number of retired instructions in the current or last run.

## Operation

- States: IDLE, INIT, RUN, DONE, FAULT. Encoded state register; `busy`, `done` and `timeout` are Moore decodes of the state.
- **IDLE**
  - All outputs are 0 except the held counters and `start_addr`.
  - `req`=1: latch `prog_sel`, set `start_addr`, go to INIT.
- **INIT** (exactly 1 cycle)
  - `pc_init`=1, `busy`=1.
  - `cycle_cnt` and `instr_cnt` clear to 0.
  - Next state is RUN.
- **RUN**
  - Define `atend` = (`prog_ctr` == END_PC).
  - `retire` = ~`stall` & ~`atend`.
  - `pc_en` = `retire` & ~`halt`. A halt retires but the PC does not move.
  - `cycle_cnt` increments every RUN cycle.
  - `instr_cnt` increments when `retire`=1.
  - Transitions, in priority order:
    - `atend` or (`halt` & `retire`): go to DONE.
    - Otherwise, `cycle_cnt` == TIMEOUT-1 (pre-increment value): go to FAULT.
    - Otherwise, stay in RUN.
  - Completion beats timeout when both occur in the same cycle.
- **DONE**
  - `done`=1; `pc_en`=0; counters hold.
  - `req`=0: go to IDLE. While `req` stays 1, remain in DONE; no auto-restart.
- **FAULT**
  - `done`=1 and `timeout`=1; counters hold.
  - Exits to IDLE under the same `req`=0 rule as DONE.
- **`req` outside IDLE**
  - A drop of `req` during INIT or RUN is ignored; the run completes.
  - `prog_sel` changes after latching are ignored.
- **Arithmetic**
  - Counters never wrap: `cycle_cnt` ≤ TIMEOUT and `instr_cnt` ≤ `cycle_cnt`.
  - `start_addr` multiply is implemented as a shift when STRIDE is a power of 2; upper bits are truncated to D.
- **Reset**
  - `Start`=1 forces IDLE on the next edge from any state, including mid-run.
  - `start_addr`, `cycle_cnt` and `instr_cnt` go to 0; every output is 0.
  - `Start` has priority over `req`.

## Timing

- Edge k samples `req`=1 in IDLE. Then:
  - Cycle k+1 is INIT, with `pc_init`=1.
  - Cycle k+2 is the first RUN cycle, with `prog_ctr` == `start_addr`.
- Run end: `done` rises 1 cycle after the terminating RUN cycle.
- Handshake release: `req` sampled 0 in DONE or FAULT gives `done`=0 in the next cycle (IDLE).
  - `req` may be reasserted in that IDLE cycle; the next INIT then follows 1 cycle later.
- `pc_en` and `pc_init` are combinational from state and the `stall`/`halt`/`prog_ctr` inputs, with no extra latency. All other outputs are registered.
- `stall` held high in RUN:
  - `pc_en`=0 and `instr_cnt` frozen.
  - `cycle_cnt` keeps counting, so the watchdog still fires.

## Test plan

- **Reset:** `Start`=1 for 2 cycles with `req`=1. Required: IDLE, every output 0.
  - Release `Start` with `req`=1 and `prog_sel`=2. Required: INIT next cycle with `start_addr`=512 (D=12).
- **Halt run:** `prog_sel`=0, no stall, `halt` asserted when `prog_ctr`=5. Required:
  - `instr_cnt`=6 and `cycle_cnt`=6.
  - `done`=1 one cycle later, with `pc_en`=0 in the halt cycle.
- **End-of-program with stalls:** `stall`=1 on 3 separate cycles, PC reaches 128 with no halt. Required:
  - `instr_cnt`=128 and `cycle_cnt`=132.
  - The instruction at PC 128 is not counted.
- **Watchdog:** TIMEOUT=20, `stall` held 1. Required:
  - FAULT after exactly 20 RUN cycles, with `done`=1, `timeout`=1, `cycle_cnt`=20, `instr_cnt`=0.
- **Simultaneous completion and timeout:** TIMEOUT=10 with `halt` retiring in RUN cycle 10. Required: DONE, `timeout`=0.
- **Handshake and mid-run reset:**
  - Hold `req`=1 for 5 cycles after `done`. Required: stays in DONE; drop `req`, then IDLE next cycle.
  - Pulse `Start` in RUN cycle 3. Required: IDLE next edge, counters 0.
